// File: rtl/mem_access_unit.sv
// Load/store engine: captures one access, runs an aligned bus transaction with byte enables
// and returns extended load data. Define MEM_SPLIT_MISALIGNED_EN to split misaligned accesses.
module mem_access_unit #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_op,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [XLEN-1:0]       resp_rdata,
  output logic                  resp_err,
  output logic                  bus_req,
  input  logic                  bus_gnt,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [XLEN/8-1:0]     bus_be,
  output logic [XLEN-1:0]       bus_wdata,
  input  logic                  bus_rvalid,
  input  logic [XLEN-1:0]       bus_rdata,
  input  logic                  bus_err
);

  localparam int NB  = XLEN / 8;
  localparam int OFS = $clog2(NB);

`ifdef MEM_SPLIT_MISALIGNED_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_WAIT, S_RESP} state_e;

  state_e                state_q, state_d;
  logic                  op_q, op_d;
  logic [1:0]            size_q, size_d;
  logic                  unsigned_q, unsigned_d;
  logic [OFS-1:0]        off_q, off_d;
  logic                  need2_q, need2_d;
  logic                  beat_q, beat_d;
  logic [NB-1:0]         be_hi_q, be_hi_d;
  logic [XLEN-1:0]       wdata_hi_q, wdata_hi_d;
  logic [XLEN-1:0]       rdata_lo_q, rdata_lo_d;
  logic                  bus_we_q, bus_we_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [NB-1:0]         bus_be_q, bus_be_d;
  logic [XLEN-1:0]       bus_wdata_q, bus_wdata_d;
  logic [XLEN-1:0]       resp_rdata_q, resp_rdata_d;
  logic                  resp_err_q, resp_err_d;

  // Request decode: lane masks and data are built double-width so the upper half
  // directly forms the second beat of a boundary-crossing access.
  logic [OFS-1:0]    req_off;
  logic [OFS-1:0]    align_mask;
  logic [2*NB-1:0]   be_base;
  logic [2*NB-1:0]   req_be_full;
  logic [2*XLEN-1:0] req_wdata_full;
  logic              req_size_bad;
  logic              req_misaligned;
  logic              req_bad;

  always_comb begin
    req_off = req_addr[OFS-1:0];
    be_base = '0;
    for (int i = 0; i < 2*NB; i++) begin
      be_base[i] = (i < (1 << req_size));
    end
    align_mask = '0;
    for (int i = 0; i < OFS; i++) begin
      align_mask[i] = (i < int'(req_size));
    end
    req_be_full    = be_base << req_off;
    req_wdata_full = {{XLEN{1'b0}}, req_wdata} << {req_off, 3'b000};
    req_size_bad   = (XLEN == 32) && (req_size == 2'd3);
    req_misaligned = |(req_off & align_mask);
    req_bad        = req_size_bad || (req_misaligned && !SPLIT_EN);
  end

  // Load path: beat 0 data sits in the low half, beat 1 (if any) in the high half.
  logic [2*XLEN-1:0] ld_merged;
  logic [XLEN-1:0]   ld_shifted;
  logic [XLEN-1:0]   ld_data;
  logic              ld_sign;
  int                ld_width;

  always_comb begin
    ld_merged  = beat_q ? {bus_rdata, rdata_lo_q} : {{XLEN{1'b0}}, bus_rdata};
    ld_shifted = XLEN'(ld_merged >> {off_q, 3'b000});
    ld_width   = 8 << size_q;
    case (size_q)
      2'd0:    ld_sign = ld_shifted[7];
      2'd1:    ld_sign = ld_shifted[15];
      2'd2:    ld_sign = ld_shifted[31];
      default: ld_sign = ld_shifted[XLEN-1];
    endcase
    ld_sign = ld_sign && !unsigned_q;
    ld_data = '0;
    for (int i = 0; i < XLEN; i++) begin
      ld_data[i] = (i < ld_width) ? ld_shifted[i] : ld_sign;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      op_q         <= 1'b0;
      size_q       <= 2'd0;
      unsigned_q   <= 1'b0;
      off_q        <= '0;
      need2_q      <= 1'b0;
      beat_q       <= 1'b0;
      be_hi_q      <= '0;
      wdata_hi_q   <= '0;
      rdata_lo_q   <= '0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_be_q     <= '0;
      bus_wdata_q  <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      size_q       <= size_d;
      unsigned_q   <= unsigned_d;
      off_q        <= off_d;
      need2_q      <= need2_d;
      beat_q       <= beat_d;
      be_hi_q      <= be_hi_d;
      wdata_hi_q   <= wdata_hi_d;
      rdata_lo_q   <= rdata_lo_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_be_q     <= bus_be_d;
      bus_wdata_q  <= bus_wdata_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    size_d       = size_q;
    unsigned_d   = unsigned_q;
    off_d        = off_q;
    need2_d      = need2_q;
    beat_d       = beat_q;
    be_hi_d      = be_hi_q;
    wdata_hi_d   = wdata_hi_q;
    rdata_lo_d   = rdata_lo_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_be_d     = bus_be_q;
    bus_wdata_d  = bus_wdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d       = req_op;
          size_d     = req_size;
          unsigned_d = req_unsigned;
          off_d      = req_off;
          beat_d     = 1'b0;
          if (req_bad) begin
            need2_d      = 1'b0;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
            state_d      = S_RESP;
          end else begin
            bus_we_d    = !req_op;
            bus_addr_d  = {req_addr[ADDR_WIDTH-1:OFS], {OFS{1'b0}}};
            bus_be_d    = req_be_full[NB-1:0];
            bus_wdata_d = req_wdata_full[XLEN-1:0];
            be_hi_d     = req_be_full[2*NB-1:NB];
            wdata_hi_d  = req_wdata_full[2*XLEN-1:XLEN];
            // Only accesses that actually spill into the next word need a second beat.
            need2_d     = SPLIT_EN && (|req_be_full[2*NB-1:NB]);
            resp_err_d  = 1'b0;
            state_d     = S_BUS;
          end
        end
      end
      S_BUS: begin
        if (bus_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus_rvalid) begin
          if (bus_err) begin
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
            state_d      = S_RESP;
          end else if (need2_q && !beat_q) begin
            beat_d      = 1'b1;
            rdata_lo_d  = bus_rdata;
            bus_addr_d  = bus_addr_q + ADDR_WIDTH'(NB);
            bus_be_d    = be_hi_q;
            bus_wdata_d = wdata_hi_q;
            state_d     = S_BUS;
          end else begin
            resp_rdata_d = op_q ? ld_data : '0;
            resp_err_d   = 1'b0;
            state_d      = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready  = (state_q == S_IDLE);
  assign bus_req    = (state_q == S_BUS);
  assign resp_valid = (state_q == S_RESP);
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_be     = bus_be_q;
  assign bus_wdata  = bus_wdata_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit (XLEN=32): expected bus beats and responses are queued
// by the stimulus and checked by independent bus-responder and response-monitor processes.
`timescale 1ns/1ps
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_op = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        bus_req;
  logic        bus_gnt = 1'b0;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        bus_err = 1'b0;

  always #5 clk = ~clk;

  mem_access_unit #(.XLEN(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  typedef struct {logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; logic we;} bus_t;
  typedef struct {logic [31:0] data; logic err;} dat_t;

  bus_t exp_bus[$];
  dat_t rd_q[$];
  dat_t exp_resp[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   resp_cnt = 0;
  int   gnt_stall = 0;
  int   resp_stall = 0;
  bit   no_rvalid = 1'b0;
  bit   bus_pending = 1'b0;
  bus_t cur_beat;
  dat_t cur_rd;
  dat_t cur_resp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_req_ready"},  32'(req_ready),  32'd1);
    chk({tag, "_bus_req"},    32'(bus_req),    32'd0);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_rdata"}, resp_rdata,      32'd0);
    chk({tag, "_resp_err"},   32'(resp_err),   32'd0);
    chk({tag, "_bus_we"},     32'(bus_we),     32'd0);
    chk({tag, "_bus_addr"},   bus_addr,        32'd0);
    chk({tag, "_bus_be"},     32'(bus_be),     32'd0);
    chk({tag, "_bus_wdata"},  bus_wdata,       32'd0);
  endtask

  // Bus responder: checks every BUS-state cycle against the expected beat, then grants and acks.
  initial begin
    forever begin
      @(negedge clk);
      bus_gnt    = 1'b0;
      bus_rvalid = 1'b0;
      bus_rdata  = '0;
      bus_err    = 1'b0;
      if (!reset_n) begin
        bus_pending = 1'b0;
      end else if (bus_pending) begin
        bus_pending = 1'b0;
        chk("rd_data_available", 32'(rd_q.size() > 0), 32'd1);
        if (rd_q.size() > 0) begin
          cur_rd     = rd_q.pop_front();
          bus_rvalid = 1'b1;
          bus_rdata  = cur_rd.data;
          bus_err    = cur_rd.err;
        end
      end else if (bus_req) begin
        chk("bus_req_ready_low", 32'(req_ready), 32'd0);
        if (exp_bus.size() == 0) begin
          chk("bus_req_unexpected", 32'(bus_req), 32'd0);
        end else begin
          cur_beat = exp_bus[0];
          chk("bus_addr",  bus_addr,        cur_beat.addr);
          chk("bus_be",    32'(bus_be),     32'(cur_beat.be));
          chk("bus_wdata", bus_wdata,       cur_beat.wdata);
          chk("bus_we",    32'(bus_we),     32'(cur_beat.we));
          if (gnt_stall > 0) begin
            gnt_stall--;
          end else begin
            bus_gnt = 1'b1;
            void'(exp_bus.pop_front());
            bus_pending = !no_rvalid;
          end
        end
      end
    end
  end

  // Response monitor: compares every RESP cycle (so held data is checked too), then accepts.
  initial begin
    forever begin
      @(negedge clk);
      resp_ready = 1'b0;
      if (reset_n && resp_valid) begin
        chk("resp_req_ready_low", 32'(req_ready), 32'd0);
        if (exp_resp.size() == 0) begin
          chk("resp_valid_unexpected", 32'(resp_valid), 32'd0);
        end else begin
          cur_resp = exp_resp[0];
          chk("resp_rdata", resp_rdata,     cur_resp.data);
          chk("resp_err",   32'(resp_err),  32'(cur_resp.err));
          if (resp_stall > 0) begin
            resp_stall--;
          end else begin
            resp_ready = 1'b1;
            void'(exp_resp.pop_front());
            resp_cnt++;
          end
        end
      end
    end
  end

  task automatic drive_req(input logic op, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
    int cyc;
    cyc = 0;
    while (!req_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("req_ready_timeout", 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_op       = op;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    @(negedge clk);
    req_valid    = 1'b0;
  endtask

  task automatic issue(input logic op, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, output int lat);
    int target;
    int cyc;
    target = resp_cnt + 1;
    drive_req(op, size, uns, addr, wdata);
    lat = -1;
    cyc = 1;
    while (cyc < 200) begin
      if (resp_valid && lat < 0) lat = cyc;
      if (resp_cnt >= target) break;
      @(negedge clk);
      cyc++;
    end
    chk("resp_timeout", 32'(resp_cnt >= target), 32'd1);
  endtask

  task automatic beat(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                      input logic we, input logic [31:0] rd, input logic err);
    exp_bus.push_back('{a, be, wd, we});
    rd_q.push_back('{rd, err});
  endtask

  task automatic expect_resp(input logic [31:0] d, input logic err);
    exp_resp.push_back('{d, err});
  endtask

  initial begin
    int lat;
    int cyc;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // lb 0x1003 signed, then unsigned
    beat(32'h1000, 4'b1000, 32'h0, 1'b0, 32'h80FF_FFFF, 1'b0);
    expect_resp(32'hFFFF_FF80, 1'b0);
    issue(1'b1, 2'd0, 1'b0, 32'h1003, 32'h0, lat);
    chk("lb_latency", 32'(lat), 32'd3);
    $display("lb  0x1003 signed   done, latency %0d", lat);

    beat(32'h1000, 4'b1000, 32'h0, 1'b0, 32'h80FF_FFFF, 1'b0);
    expect_resp(32'h0000_0080, 1'b0);
    issue(1'b1, 2'd0, 1'b1, 32'h1003, 32'h0, lat);
    $display("lbu 0x1003          done");

    // sh 0x2002
    beat(32'h2000, 4'b1100, 32'hBEEF_0000, 1'b1, 32'h0, 1'b0);
    expect_resp(32'h0, 1'b0);
    issue(1'b0, 2'd1, 1'b0, 32'h2002, 32'h0000_BEEF, lat);
    $display("sh  0x2002          done");

    // lw 0x3001 misaligned
`ifdef MEM_SPLIT_MISALIGNED_EN
    beat(32'h3000, 4'b1110, 32'h0, 1'b0, 32'hDDCC_BBAA, 1'b0);
    beat(32'h3004, 4'b0001, 32'h0, 1'b0, 32'h0000_00EE, 1'b0);
    expect_resp(32'hEEDD_CCBB, 1'b0);
`else
    expect_resp(32'h0, 1'b1);
`endif
    issue(1'b1, 2'd2, 1'b0, 32'h3001, 32'h0, lat);
    $display("lw  0x3001 misaligned done");

    // sw with grant stalled 5 cycles and response stalled 3 cycles
    gnt_stall  = 5;
    resp_stall = 3;
    beat(32'h5004, 4'b1111, 32'h1234_5678, 1'b1, 32'h0, 1'b0);
    expect_resp(32'h0, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h5004, 32'h1234_5678, lat);
    $display("sw  0x5004 stalled  done, latency %0d", lat);

    // bus error on read
    beat(32'h4000, 4'b1111, 32'h0, 1'b0, 32'hFFFF_FFFF, 1'b1);
    expect_resp(32'h0, 1'b1);
    issue(1'b1, 2'd2, 1'b0, 32'h4000, 32'h0, lat);
    $display("lw  0x4000 bus_err  done");

    // size 3 illegal on XLEN=32
    expect_resp(32'h0, 1'b1);
    issue(1'b1, 2'd3, 1'b0, 32'h4000, 32'h0, lat);
    $display("ld  0x4000 illegal  done");

    // halfword loads and full word
    beat(32'h6000, 4'b1100, 32'h0, 1'b0, 32'h8001_1234, 1'b0);
    expect_resp(32'hFFFF_8001, 1'b0);
    issue(1'b1, 2'd1, 1'b0, 32'h6002, 32'h0, lat);
    $display("lh  0x6002          done");

    beat(32'h6000, 4'b0011, 32'h0, 1'b0, 32'h1234_ABCD, 1'b0);
    expect_resp(32'h0000_ABCD, 1'b0);
    issue(1'b1, 2'd1, 1'b1, 32'h6000, 32'h0, lat);
    $display("lhu 0x6000          done");

    beat(32'h7000, 4'b1111, 32'h0, 1'b0, 32'hCAFE_F00D, 1'b0);
    expect_resp(32'hCAFE_F00D, 1'b0);
    issue(1'b1, 2'd2, 1'b0, 32'h7000, 32'h0, lat);
    $display("lw  0x7000          done");

    beat(32'h1000, 4'b0010, 32'h0000_A500, 1'b1, 32'h0, 1'b0);
    expect_resp(32'h0, 1'b0);
    issue(1'b0, 2'd0, 1'b0, 32'h1001, 32'h0000_00A5, lat);
    $display("sb  0x1001          done");

    // reset asserted while waiting for read data
    no_rvalid = 1'b1;
    exp_bus.push_back('{32'h8000, 4'b1111, 32'h0, 1'b0});
    drive_req(1'b1, 2'd2, 1'b0, 32'h8000, 32'h0);
    cyc = 0;
    while (exp_bus.size() != 0 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("wait_gnt_timeout", 32'(exp_bus.size()), 32'd0);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check_idle_outputs("midreset");
    @(negedge clk);
    reset_n   = 1'b1;
    no_rvalid = 1'b0;
    @(negedge clk);
    $display("reset during WAIT   done");

    beat(32'h1000, 4'b0001, 32'h0, 1'b0, 32'h0000_00A5, 1'b0);
    expect_resp(32'h0000_00A5, 1'b0);
    issue(1'b1, 2'd0, 1'b1, 32'h1000, 32'h0, lat);
    chk("post_reset_latency", 32'(lat), 32'd3);
    $display("lbu 0x1000 post-rst done, latency %0d", lat);

    repeat (5) @(negedge clk);
    chk("exp_resp_left", 32'(exp_resp.size()), 32'd0);
    chk("exp_bus_left",  32'(exp_bus.size()),  32'd0);
    chk("rd_q_left",     32'(rd_q.size()),     32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
